// File: rtl/sobel_edge_detect_3x3.sv
// -----------------------------------------------------------------------------
// sobel_edge_detect_3x3
//
// Sobel edge detector behind the two-line shift RAM. The current grey pixel and
// the two previous-line taps build a sliding 3x3 window. The gradient magnitude
// |Gx|+|Gy| saturates to 8 bits and is compared against a runtime threshold to
// give a 1-bit edge map. Frame syncs are delayed by the pipeline depth (5).
//
// Strobe semantics: there is no back-pressure. A pixel is transferred in every
// cycle where pre_frame_clken is high. The RAM taps belonging to that pixel are
// presented one cycle later. post_frame_clken marks every cycle in which
// post_grad / post_img_bit carry a new result. Between strobes the results hold.
//
// Parameters:
//   CNT_W            width of the line / column counters (border mask only)
//
// Ports:
//   clock            pixel clock
//   rst_n            synchronous active-low reset
//   pre_frame_vsync  input frame sync, active high
//   pre_frame_href   input line valid
//   pre_frame_clken  input pixel strobe
//   pre_img_y        current-line pixel (also feeds the line RAM)
//   taps0x           previous-line pixel, valid 1 cycle after the strobe
//   taps1x           line-before-previous pixel, valid 1 cycle after the strobe
//   threshold        edge threshold, sampled every cycle
//   post_frame_vsync vsync delayed by 5
//   post_frame_href  href delayed by 5
//   post_frame_clken clken delayed by 5
//   post_grad        saturated gradient magnitude
//   post_img_bit     1 = edge (post_grad strictly greater than threshold)
//
// Build option:
//   SOBEL_BORDER_MASK_EN  when defined, line/column counters mark pixels whose
//                         window is not fully populated and their outputs are
//                         forced to 0. When undefined, there are no counters and
//                         border pixels see stale window contents.
// -----------------------------------------------------------------------------
module sobel_edge_detect_3x3 #(
  parameter int CNT_W = 11
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_href,
  input  logic       pre_frame_clken,
  input  logic [7:0] pre_img_y,
  input  logic [7:0] taps0x,
  input  logic [7:0] taps1x,
  input  logic [7:0] threshold,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_grad,
  output logic       post_img_bit
);

  // The border comparisons need at least two counter bits.
  if (CNT_W < 2) begin : g_cnt_w_check
    $error("CNT_W must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Sync delay lines. Bit 0 is stage 0 (aligned with the RAM taps); bit 4 is the
  // output. clken_sr[k] is the enable of pipeline stage k+1.
  // ---------------------------------------------------------------------------
  logic [4:0] vsync_sr;
  logic [4:0] href_sr;
  logic [4:0] clken_sr;
  logic [7:0] img_d0;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      vsync_sr <= '0;
      href_sr  <= '0;
      clken_sr <= '0;
      img_d0   <= '0;
    end else begin
      vsync_sr <= {vsync_sr[3:0], pre_frame_vsync};
      href_sr  <= {href_sr[3:0],  pre_frame_href};
      clken_sr <= {clken_sr[3:0], pre_frame_clken};
      img_d0   <= pre_img_y;
    end
  end

  assign post_frame_vsync = vsync_sr[4];
  assign post_frame_href  = href_sr[4];
  assign post_frame_clken = clken_sr[4];

  // ---------------------------------------------------------------------------
  // Stage 1: 3x3 window. pRC = row R (1 = top, oldest line), column C
  // (1 = oldest column). New data enters column 3.
  // ---------------------------------------------------------------------------
  logic [7:0] p11, p12, p13;
  logic [7:0] p21, p22, p23;
  logic [7:0] p31, p32, p33;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else if (clken_sr[0]) begin
      p11 <= p12; p12 <= p13; p13 <= taps1x;
      p21 <= p22; p22 <= p23; p23 <= taps0x;
      p31 <= p32; p32 <= p33; p33 <= img_d0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: gradients. Each side is an unsigned sum (max 4*255 = 1020, 10 bits)
  // and the difference lands in an 11-bit signed register.
  // ---------------------------------------------------------------------------
  logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;

  always_comb begin
    gx_pos = {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
    gx_neg = {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
    gy_pos = {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
    gy_neg = {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};
  end

  logic signed [10:0] gx_s2, gy_s2;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      gx_s2 <= '0;
      gy_s2 <= '0;
    end else if (clken_sr[1]) begin
      gx_s2 <= $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
      gy_s2 <= $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: magnitude |Gx|+|Gy| (0..2040) saturated to 8 bits.
  // ---------------------------------------------------------------------------
  logic [10:0] abs_x, abs_y, mag;
  logic [7:0]  grad_sat;

  always_comb begin
    abs_x    = gx_s2[10] ? 11'(-gx_s2) : 11'(gx_s2);
    abs_y    = gy_s2[10] ? 11'(-gy_s2) : 11'(gy_s2);
    mag      = abs_x + abs_y;
    grad_sat = (mag > 11'd255) ? 8'hFF : mag[7:0];
  end

  logic [7:0] grad_s3;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      grad_s3 <= '0;
    end else if (clken_sr[2]) begin
      grad_s3 <= grad_sat;
    end
  end

`ifdef SOBEL_BORDER_MASK_EN
  // ---------------------------------------------------------------------------
  // Border tracking on the stage-0 signals so the counts line up with the
  // pixel being shifted into the window. The column count seen at a stage-1
  // strobe is the index of the newest pixel.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] col_cnt;
  logic             vs_rise;
  logic             href_fall;
  logic             border_s1, border_s2, border_s3;

  assign vs_rise   = vsync_sr[0] & ~vsync_sr[1];
  assign href_fall = ~href_sr[0] & href_sr[1];

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      line_cnt <= '0;
      col_cnt  <= '0;
    end else begin
      // A frame start wins over a coincident line end.
      if (vs_rise) begin
        line_cnt <= '0;
      end else if (href_fall && (line_cnt != '1)) begin
        line_cnt <= line_cnt + 1'b1;
      end

      if (!href_sr[0]) begin
        col_cnt <= '0;
      end else if (clken_sr[0] && (col_cnt != '1)) begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      border_s1 <= 1'b0;
      border_s2 <= 1'b0;
      border_s3 <= 1'b0;
    end else begin
      if (clken_sr[0]) border_s1 <= (line_cnt < CNT_W'(2)) || (col_cnt < CNT_W'(2));
      if (clken_sr[1]) border_s2 <= border_s1;
      if (clken_sr[2]) border_s3 <= border_s2;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage 4: threshold and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      post_grad    <= '0;
      post_img_bit <= 1'b0;
    end else if (clken_sr[3]) begin
`ifdef SOBEL_BORDER_MASK_EN
      if (border_s3) begin
        post_grad    <= '0;
        post_img_bit <= 1'b0;
      end else begin
        post_grad    <= grad_s3;
        post_img_bit <= (grad_s3 > threshold);
      end
`else
      post_grad    <= grad_s3;
      post_img_bit <= (grad_s3 > threshold);
`endif
    end
  end

endmodule

// File: tb/tb_sobel_edge_detect_3x3.sv
// -----------------------------------------------------------------------------
// tb_sobel_edge_detect_3x3
//
// Drives 64x8 frames through the Sobel block with a line-RAM model supplying
// the taps one cycle after each pixel strobe. Expected results per pixel are
// queued at drive time and popped on every post_frame_clken.
// Expected-queue entry: {interior, check, edge_bit, grad[7:0]}.
// -----------------------------------------------------------------------------
module tb_sobel_edge_detect_3x3;

  localparam int IMG_W = 64;
  localparam int IMG_H = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b1;
  always #5 clock = ~clock;

  logic       rst_n;
  logic       pre_frame_vsync, pre_frame_href, pre_frame_clken;
  logic [7:0] pre_img_y, taps0x, taps1x, threshold;
  logic       post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0] post_grad;
  logic       post_img_bit;

  sobel_edge_detect_3x3 #(.CNT_W(11)) dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_href   (pre_frame_href),
    .pre_frame_clken  (pre_frame_clken),
    .pre_img_y        (pre_img_y),
    .taps0x           (taps0x),
    .taps1x           (taps1x),
    .threshold        (threshold),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_grad        (post_grad),
    .post_img_bit     (post_img_bit)
  );

  // ---------------------------------------------------------------- state
  typedef struct {
    int         pat;        // 0 flat, 1 vertical step, 2 horizontal step, 3 random
    logic [7:0] thr;
    int         frames;
    int         gap;        // idle cycles after each pixel strobe
    int         exp_edges;  // interior edge pixels in last frame, -1 = not checked
  } vec_t;

  int          errors;
  int          checks;
  int          cyc;
  int          pulses;
  int          edges;
  int          zero_cnt;
  bit          lat_en;
  logic [10:0] exp_q[$];
  logic        hv[64], hh[64], hc[64];
  logic [7:0]  ram1[IMG_W];
  logic [7:0]  ram2[IMG_W];
  logic [7:0]  rnd_img[IMG_H][IMG_W];
  vec_t        vecs[5];

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 128;
      1:       return (c < 10) ? 0 : 255;
      2:       return (r < 4) ? 0 : 40;
      default: return int'(rnd_img[r][c]);
    endcase
  endfunction

  // Expected output for the window whose newest pixel is (r, c).
  function automatic logic [10:0] expect_pix(input int pat, input int r, input int c,
                                             input logic [7:0] thr, input bit check_all);
    int gx, gy, mag, sat;
    logic b;
    if (r >= 2 && c >= 2) begin
      gx = (pix(pat, r-2, c) + 2*pix(pat, r-1, c) + pix(pat, r, c))
         - (pix(pat, r-2, c-2) + 2*pix(pat, r-1, c-2) + pix(pat, r, c-2));
      gy = (pix(pat, r, c-2) + 2*pix(pat, r, c-1) + pix(pat, r, c))
         - (pix(pat, r-2, c-2) + 2*pix(pat, r-2, c-1) + pix(pat, r-2, c));
      mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      sat = (mag > 255) ? 255 : mag;
      b   = (sat > int'(thr));
      return {1'b1, 1'b1, b, 8'(sat)};
    end
`ifdef SOBEL_BORDER_MASK_EN
    return {1'b0, 1'b1, 1'b0, 8'd0};
`else
    if (check_all) return {1'b0, 1'b1, 1'b0, 8'd0};
    return {1'b0, 1'b0, 1'b0, 8'd0};
`endif
  endfunction

  task automatic monitor();
    logic [10:0] e;
    int idx;
    if (zero_cnt > 0) begin
      check("reset_vsync", 32'(post_frame_vsync), 0);
      check("reset_href",  32'(post_frame_href),  0);
      check("reset_clken", 32'(post_frame_clken), 0);
      check("reset_grad",  32'(post_grad),        0);
      check("reset_bit",   32'(post_img_bit),     0);
      zero_cnt--;
    end
    if (lat_en) begin
      idx = (cyc - 5) % 64;
      check("lat_vsync", 32'(post_frame_vsync), 32'(hv[idx]));
      check("lat_href",  32'(post_frame_href),  32'(hh[idx]));
      check("lat_clken", 32'(post_frame_clken), 32'(hc[idx]));
    end
    if (post_frame_clken === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got post_frame_clken=1 expected no pending pixel (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        pulses++;
        if (e[9]) begin
          check("grad", 32'(post_grad), 32'(e[7:0]));
          check("edge_bit", 32'(post_img_bit), 32'(e[8]));
        end
        if (e[10] && post_img_bit === 1'b1) edges++;
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // One clock cycle: record inputs, sample outputs at negedge, then cross the
  // active edge and return 1 time unit after it.
  task automatic step();
    hv[cyc % 64] = pre_frame_vsync;
    hh[cyc % 64] = pre_frame_href;
    hc[cyc % 64] = pre_frame_clken;
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One input cycle; on a strobe the line-RAM model presents the taps for this
  // pixel in the following cycle.
  task automatic drive_pix(input logic v, input logic h, input logic ck,
                           input logic [7:0] y, input int col);
    pre_frame_vsync = v;
    pre_frame_href  = h;
    pre_frame_clken = ck;
    pre_img_y       = y;
    step();
    if (ck) begin
      taps0x    = ram1[col];
      taps1x    = ram2[col];
      ram2[col] = ram1[col];
      ram1[col] = y;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit last, check_all;
    threshold = v.thr;
    for (int f = 0; f < v.frames; f++) begin
      last      = (f == v.frames - 1);
      check_all = last && (v.pat == 0);
      pulses    = 0;
      edges     = 0;
      repeat (2) drive_pix(1'b1, 1'b0, 1'b0, 8'h00, 0);
      repeat (2) drive_pix(1'b0, 1'b0, 1'b0, 8'h00, 0);
      for (int r = 0; r < IMG_H; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          exp_q.push_back(expect_pix(v.pat, r, c, v.thr, check_all));
          drive_pix(1'b0, 1'b1, 1'b1, 8'(pix(v.pat, r, c)), c);
          for (int g = 0; g < v.gap; g++) drive_pix(1'b0, 1'b1, 1'b0, 8'h00, 0);
        end
        repeat (3) drive_pix(1'b0, 1'b0, 1'b0, 8'h00, 0);
      end
      repeat (8) drive_pix(1'b0, 1'b0, 1'b0, 8'h00, 0);
      check($sformatf("frame_pulses_pat%0d", v.pat), 32'(pulses), 32'(IMG_W * IMG_H));
      check($sformatf("frame_queue_empty_pat%0d", v.pat), 32'(exp_q.size()), 0);
      if (last && v.exp_edges >= 0)
        check($sformatf("edge_count_pat%0d_thr%0d", v.pat, v.thr), 32'(edges), 32'(v.exp_edges));
    end
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    pulses   = 0;
    edges    = 0;
    zero_cnt = 0;
    lat_en   = 1'b0;
    for (int c = 0; c < IMG_W; c++) begin
      ram1[c] = 8'h00;
      ram2[c] = 8'h00;
      for (int r = 0; r < IMG_H; r++) rnd_img[r][c] = 8'($urandom_range(0, 255));
    end

    // Flat frame run twice so the second frame sees flat RAM and window history.
    vecs[0] = '{pat: 0, thr: 8'd10,  frames: 2, gap: 0, exp_edges: 0};
    // Vertical step: window centres 9 and 10 on lines 2..7 -> 6 * 2.
    vecs[1] = '{pat: 1, thr: 8'd100, frames: 1, gap: 0, exp_edges: 12};
    // Horizontal step of 40: mag 160 on lines 4 and 5, interior columns 2..63.
    vecs[2] = '{pat: 2, thr: 8'd159, frames: 1, gap: 0, exp_edges: 124};
    vecs[3] = '{pat: 2, thr: 8'd160, frames: 1, gap: 0, exp_edges: 0};
    // Random pixels, gapped strobes.
    vecs[4] = '{pat: 3, thr: 8'd0,   frames: 1, gap: 2, exp_edges: -1};

    // Power-up reset.
    rst_n           = 1'b0;
    pre_frame_vsync = 1'b0;
    pre_frame_href  = 1'b0;
    pre_frame_clken = 1'b0;
    pre_img_y       = 8'h00;
    taps0x          = 8'h00;
    taps1x          = 8'h00;
    threshold       = 8'h00;
    step();
    zero_cnt = 3;
    step();
    step();
    rst_n = 1'b1;
    step();
    repeat (2) step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Latency/alignment: strobes separated by 3 idle cycles; every output sync
    // must equal the corresponding input 5 cycles earlier.
    pulses = 0;
    lat_en = 1'b1;
    repeat (2) drive_pix(1'b1, 1'b0, 1'b0, 8'h00, 0);
    repeat (2) drive_pix(1'b0, 1'b0, 1'b0, 8'h00, 0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(11'd0);
      drive_pix(1'b0, 1'b1, 1'b1, 8'(k * 30), k);
      repeat (3) drive_pix(1'b0, 1'b1, 1'b0, 8'h00, 0);
    end
    repeat (8) drive_pix(1'b0, 1'b0, 1'b0, 8'h00, 0);
    lat_en = 1'b0;
    check("lat_pulses", 32'(pulses), 8);
    check("lat_queue_empty", 32'(exp_q.size()), 0);

    // Mid-line reset: load the window with a bright bottom row, reset for 3
    // cycles with strobes still active, then push one black pixel. A cleared
    // window gives gradient 0; stale content would not.
    threshold       = 8'h00;
    pre_frame_href  = 1'b1;
    pre_frame_vsync = 1'b0;
    taps0x          = 8'h00;
    taps1x          = 8'h00;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(11'd0);
      pre_frame_clken = 1'b1;
      pre_img_y       = 8'hFF;
      step();
    end
    rst_n = 1'b0;
    step();
    exp_q.delete();
    zero_cnt = 7;
    step();
    step();
    rst_n           = 1'b1;
    pre_frame_clken = 1'b0;
    step();
    repeat (4) step();
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'd0});
    pre_frame_clken = 1'b1;
    pre_img_y       = 8'h00;
    step();
    pre_frame_clken = 1'b0;
    pre_frame_href  = 1'b0;
    repeat (8) step();
    check("reset_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
